// File: rtl/writeback_stage_if.sv
// Signal bundle between the memory/decode stages and the writeback stage.
// The master drives the I_* side and the slave (writeback_stage) drives the O_* side.
interface writeback_stage_if #(
    parameter int REG_WIDTH    = 16,
    parameter int NUM_REGS     = 16,
    parameter int IDX_WIDTH    = 4,
    parameter int OPCODE_WIDTH = 8,
    parameter int CNT_WIDTH    = 32
);
    logic                    I_LOCK;
    logic [REG_WIDTH-1:0]    I_ALUOut;
    logic [REG_WIDTH-1:0]    I_MemOut;
    logic [OPCODE_WIDTH-1:0] I_Opcode;
    logic [IDX_WIDTH-1:0]    I_DestRegIdx;
    logic                    I_FetchStall;
    logic                    I_DepStall;
    logic                    I_SetBusy;
    logic [IDX_WIDTH-1:0]    I_SetBusyIdx;
    logic [IDX_WIDTH-1:0]    I_RdIdx1;
    logic [IDX_WIDTH-1:0]    I_RdIdx2;

    logic                    O_LOCK;
    logic [REG_WIDTH-1:0]    O_RdData1;
    logic [REG_WIDTH-1:0]    O_RdData2;
    logic [NUM_REGS-1:0]     O_Busy;
    logic                    O_WBEnable;
    logic [IDX_WIDTH-1:0]    O_WBRegIdx;
    logic [REG_WIDTH-1:0]    O_WBData;
    logic [CNT_WIDTH-1:0]    O_RetireCount;
    logic [CNT_WIDTH-1:0]    O_StallCount;

    modport master (
        output I_LOCK, I_ALUOut, I_MemOut, I_Opcode, I_DestRegIdx,
               I_FetchStall, I_DepStall, I_SetBusy, I_SetBusyIdx,
               I_RdIdx1, I_RdIdx2,
        input  O_LOCK, O_RdData1, O_RdData2, O_Busy, O_WBEnable,
               O_WBRegIdx, O_WBData, O_RetireCount, O_StallCount
    );

    modport slave (
        input  I_LOCK, I_ALUOut, I_MemOut, I_Opcode, I_DestRegIdx,
               I_FetchStall, I_DepStall, I_SetBusy, I_SetBusyIdx,
               I_RdIdx1, I_RdIdx2,
        output O_LOCK, O_RdData1, O_RdData2, O_Busy, O_WBEnable,
               O_WBRegIdx, O_WBData, O_RetireCount, O_StallCount
    );
endinterface

// File: rtl/writeback_stage.sv
// Final pipeline stage: retires instructions into the register file, serves two
// bypassed read ports, tracks the busy scoreboard and keeps retire/stall counters.
module writeback_stage #(
    parameter int REG_WIDTH    = 16,
    parameter int NUM_REGS     = 16,
    parameter int IDX_WIDTH    = 4,
    parameter int OPCODE_WIDTH = 8,
    parameter int CNT_WIDTH    = 32
) (
    input  logic             I_CLOCK,
    input  logic             I_RESET,
    writeback_stage_if.slave wb
);
    localparam logic [OPCODE_WIDTH-1:0] OP_NOP   = OPCODE_WIDTH'(8'h00);
    localparam logic [OPCODE_WIDTH-1:0] OP_LDW   = OPCODE_WIDTH'(8'h10);
    localparam logic [OPCODE_WIDTH-1:0] OP_STW   = OPCODE_WIDTH'(8'h11);
    localparam logic [OPCODE_WIDTH-1:0] OP_BRN   = OPCODE_WIDTH'(8'h20);
    localparam logic [OPCODE_WIDTH-1:0] OP_BRNZP = OPCODE_WIDTH'(8'h26);
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP   = OPCODE_WIDTH'(8'h30);

    logic [REG_WIDTH-1:0] regs_q [NUM_REGS];

    logic                 lock_q,   lock_d;
    logic [NUM_REGS-1:0]  busy_q,   busy_d;
    logic                 wb_en_q,  wb_en_d;
    logic [IDX_WIDTH-1:0] wb_idx_q, wb_idx_d;
    logic [REG_WIDTH-1:0] wb_data_q, wb_data_d;
    logic [CNT_WIDTH-1:0] retire_q, retire_d;
    logic [CNT_WIDTH-1:0] stall_q,  stall_d;

    logic                 valid;
    logic                 bubble;
    logic                 is_branch;
    logic                 writes_reg;
    logic                 commit;
    logic [REG_WIDTH-1:0] wr_data;

    // Instruction decode for the current stage occupant.
    assign bubble     = wb.I_FetchStall | wb.I_DepStall;
    assign valid      = wb.I_LOCK & ~bubble;
    assign is_branch  = (wb.I_Opcode >= OP_BRN) && (wb.I_Opcode <= OP_BRNZP);
    assign writes_reg = !((wb.I_Opcode == OP_STW) || is_branch ||
                          (wb.I_Opcode == OP_JMP) || (wb.I_Opcode == OP_NOP));
    assign commit     = valid & writes_reg;
    assign wr_data    = (wb.I_Opcode == OP_LDW) ? wb.I_MemOut : wb.I_ALUOut;

    always_ff @(negedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            regs_q[wb.I_DestRegIdx] <= wr_data;
        end
    end

    // Read ports see a same-cycle commit so decode never reads a stale value.
    logic [IDX_WIDTH-1:0] rd_idx  [2];
    logic [REG_WIDTH-1:0] rd_data [2];

    assign rd_idx[0] = wb.I_RdIdx1;
    assign rd_idx[1] = wb.I_RdIdx2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
            assign rd_data[gi] = (commit && (wb.I_DestRegIdx == rd_idx[gi])) ?
                                 wr_data : regs_q[rd_idx[gi]];
        end
    endgenerate

    assign wb.O_RdData1 = rd_data[0];
    assign wb.O_RdData2 = rd_data[1];

    always_comb begin
        lock_d    = wb.I_LOCK;
        busy_d    = busy_q;
        wb_en_d   = commit;
        wb_idx_d  = wb_idx_q;
        wb_data_d = wb_data_q;
        retire_d  = retire_q;
        stall_d   = stall_q;

        if (commit) begin
            busy_d[wb.I_DestRegIdx] = 1'b0;
            wb_idx_d  = wb.I_DestRegIdx;
            wb_data_d = wr_data;
        end
        // Applied after the clear: a new claim outranks the retiring producer.
        if (wb.I_LOCK && wb.I_SetBusy) begin
            busy_d[wb.I_SetBusyIdx] = 1'b1;
        end
        if (valid) begin
            retire_d = retire_q + CNT_WIDTH'(1);
        end
        if (wb.I_LOCK && bubble) begin
            stall_d = stall_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(negedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            lock_q    <= 1'b0;
            busy_q    <= '0;
            wb_en_q   <= 1'b0;
            wb_idx_q  <= '0;
            wb_data_q <= '0;
            retire_q  <= '0;
            stall_q   <= '0;
        end else begin
            lock_q    <= lock_d;
            busy_q    <= busy_d;
            wb_en_q   <= wb_en_d;
            wb_idx_q  <= wb_idx_d;
            wb_data_q <= wb_data_d;
            retire_q  <= retire_d;
            stall_q   <= stall_d;
        end
    end

    assign wb.O_LOCK        = lock_q;
    assign wb.O_Busy        = busy_q;
    assign wb.O_WBEnable    = wb_en_q;
    assign wb.O_WBRegIdx    = wb_idx_q;
    assign wb.O_WBData      = wb_data_q;
    assign wb.O_RetireCount = retire_q;
    assign wb.O_StallCount  = stall_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Directed vector bench for writeback_stage: table of per-cycle stimuli with
// hand-computed results, plus async-reset and counter-wrap sequences.
module tb_writeback_stage;
    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_LDW = 8'h10;
    localparam logic [7:0] OP_STW = 8'h11;
    localparam logic [7:0] OP_BRZ = 8'h22;
    localparam logic [7:0] OP_JMP = 8'h30;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    writeback_stage_if #(.CNT_WIDTH(32)) wif ();
    writeback_stage_if #(.CNT_WIDTH(3))  wif_w ();

    writeback_stage #(.CNT_WIDTH(32)) dut (
        .I_CLOCK (clk),
        .I_RESET (rst),
        .wb      (wif)
    );

    writeback_stage #(.CNT_WIDTH(3)) dut_w (
        .I_CLOCK (clk),
        .I_RESET (rst),
        .wb      (wif_w)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        lock, fs, ds, setb;
        logic [3:0]  sbidx;
        logic [7:0]  op;
        logic [3:0]  dest;
        logic [15:0] alu, mem;
        logic [3:0]  rd1, rd2;
        logic [15:0] e_rd1, e_rd2;
        logic        e_wbe;
        logic [3:0]  e_idx;
        logic [15:0] e_data;
        logic [15:0] e_busy;
        logic [31:0] e_ret, e_stall;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        wif.I_LOCK       = v.lock;
        wif.I_FetchStall = v.fs;
        wif.I_DepStall   = v.ds;
        wif.I_SetBusy    = v.setb;
        wif.I_SetBusyIdx = v.sbidx;
        wif.I_Opcode     = v.op;
        wif.I_DestRegIdx = v.dest;
        wif.I_ALUOut     = v.alu;
        wif.I_MemOut     = v.mem;
        wif.I_RdIdx1     = v.rd1;
        wif.I_RdIdx2     = v.rd2;
    endtask

    task automatic idle_inputs();
        vec_t v;
        v = '{"idle", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, OP_NOP, 4'd0, 16'h0, 16'h0,
              4'd0, 4'd0, 16'h0, 16'h0, 1'b0, 4'd0, 16'h0, 16'h0, 32'd0, 32'd0};
        drive(v);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wbe"},    32'(wif.O_WBEnable),    32'd0);
        check({tag, "_idx"},    32'(wif.O_WBRegIdx),    32'd0);
        check({tag, "_data"},   32'(wif.O_WBData),      32'd0);
        check({tag, "_busy"},   32'(wif.O_Busy),        32'd0);
        check({tag, "_ret"},    wif.O_RetireCount,      32'd0);
        check({tag, "_stall"},  wif.O_StallCount,       32'd0);
        check({tag, "_lock"},   32'(wif.O_LOCK),        32'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle_inputs();
        wif_w.I_LOCK = 1'b0; wif_w.I_FetchStall = 1'b0; wif_w.I_DepStall = 1'b0;
        wif_w.I_SetBusy = 1'b0; wif_w.I_SetBusyIdx = 4'd0; wif_w.I_Opcode = OP_NOP;
        wif_w.I_DestRegIdx = 4'd0; wif_w.I_ALUOut = 16'h0; wif_w.I_MemOut = 16'h0;
        wif_w.I_RdIdx1 = 4'd0; wif_w.I_RdIdx2 = 4'd0;

        //                name            lock fs   ds   setb sbidx op      dest  alu       mem       rd1   rd2   e_rd1     e_rd2     wbe  idx   data      busy      ret    stall
        vecs.push_back('{"add_r3",       1'b1,1'b0,1'b0,1'b0,4'd0,OP_ADD,4'd3, 16'h1234,16'h0000,4'd3, 4'd0, 16'h1234,16'h0000,1'b1,4'd3, 16'h1234,16'h0000,32'd1, 32'd0});
        vecs.push_back('{"ldw_r5",       1'b1,1'b0,1'b0,1'b0,4'd0,OP_LDW,4'd5, 16'h0040,16'hBEEF,4'd5, 4'd3, 16'hBEEF,16'h1234,1'b1,4'd5, 16'hBEEF,16'h0000,32'd2, 32'd0});
        vecs.push_back('{"stw",          1'b1,1'b0,1'b0,1'b0,4'd0,OP_STW,4'd6, 16'h1111,16'h2222,4'd6, 4'd5, 16'h0000,16'hBEEF,1'b0,4'd5, 16'hBEEF,16'h0000,32'd3, 32'd0});
        vecs.push_back('{"brz",          1'b1,1'b0,1'b0,1'b0,4'd0,OP_BRZ,4'd7, 16'h2222,16'h0000,4'd7, 4'd3, 16'h0000,16'h1234,1'b0,4'd5, 16'hBEEF,16'h0000,32'd4, 32'd0});
        vecs.push_back('{"dep_bubble",   1'b1,1'b0,1'b1,1'b0,4'd0,OP_ADD,4'd8, 16'h3333,16'h0000,4'd8, 4'd5, 16'h0000,16'hBEEF,1'b0,4'd5, 16'hBEEF,16'h0000,32'd4, 32'd1});
        vecs.push_back('{"set7",         1'b1,1'b0,1'b0,1'b1,4'd7,OP_NOP,4'd0, 16'h0000,16'h0000,4'd7, 4'd0, 16'h0000,16'h0000,1'b0,4'd5, 16'hBEEF,16'h0080,32'd5, 32'd1});
        vecs.push_back('{"commit7_set7", 1'b1,1'b0,1'b0,1'b1,4'd7,OP_ADD,4'd7, 16'h7777,16'h0000,4'd7, 4'd7, 16'h7777,16'h7777,1'b1,4'd7, 16'h7777,16'h0080,32'd6, 32'd1});
        vecs.push_back('{"commit7",      1'b1,1'b0,1'b0,1'b0,4'd0,OP_ADD,4'd7, 16'h7778,16'h0000,4'd7, 4'd3, 16'h7778,16'h1234,1'b1,4'd7, 16'h7778,16'h0000,32'd7, 32'd1});
        vecs.push_back('{"set2_commit9", 1'b1,1'b0,1'b0,1'b1,4'd2,OP_ADD,4'd9, 16'h9999,16'h0000,4'd9, 4'd2, 16'h9999,16'h0000,1'b1,4'd9, 16'h9999,16'h0004,32'd8, 32'd1});
        vecs.push_back('{"unlocked",     1'b0,1'b1,1'b0,1'b1,4'd4,OP_ADD,4'd10,16'hAAAA,16'h0000,4'd10,4'd9, 16'h0000,16'h9999,1'b0,4'd9, 16'h9999,16'h0004,32'd8, 32'd1});
        vecs.push_back('{"jmp_fstall",   1'b1,1'b1,1'b0,1'b0,4'd0,OP_JMP,4'd1, 16'h5555,16'h0000,4'd1, 4'd7, 16'h0000,16'h7778,1'b0,4'd9, 16'h9999,16'h0004,32'd8, 32'd2});
        vecs.push_back('{"add_r0",       1'b1,1'b0,1'b0,1'b0,4'd0,OP_ADD,4'd0, 16'h0ABC,16'h0000,4'd0, 4'd8, 16'h0ABC,16'h0000,1'b1,4'd0, 16'h0ABC,16'h0004,32'd9, 32'd2});
        vecs.push_back('{"nop_read",     1'b1,1'b0,1'b0,1'b0,4'd0,OP_NOP,4'd0, 16'hFFFF,16'h0000,4'd0, 4'd9, 16'h0ABC,16'h9999,1'b0,4'd0, 16'h0ABC,16'h0004,32'd10,32'd2});

        // Reset state
        repeat (2) @(negedge clk);
        @(posedge clk);
        rst = 1'b0;
        #1;
        check_all_zero("reset");
        check("reset_rd1", 32'(wif.O_RdData1), 32'd0);

        // Table: combinational reads before the edge, registered outputs after it
        foreach (vecs[i]) begin
            drive(vecs[i]);
            #1;
            check({vecs[i].name, "_rd1"}, 32'(wif.O_RdData1), 32'(vecs[i].e_rd1));
            check({vecs[i].name, "_rd2"}, 32'(wif.O_RdData2), 32'(vecs[i].e_rd2));
            @(negedge clk);
            #1;
            check({vecs[i].name, "_wbe"},   32'(wif.O_WBEnable), 32'(vecs[i].e_wbe));
            check({vecs[i].name, "_idx"},   32'(wif.O_WBRegIdx), 32'(vecs[i].e_idx));
            check({vecs[i].name, "_data"},  32'(wif.O_WBData),   32'(vecs[i].e_data));
            check({vecs[i].name, "_busy"},  32'(wif.O_Busy),     32'(vecs[i].e_busy));
            check({vecs[i].name, "_ret"},   wif.O_RetireCount,   vecs[i].e_ret);
            check({vecs[i].name, "_stall"}, wif.O_StallCount,    vecs[i].e_stall);
            check({vecs[i].name, "_lock"},  32'(wif.O_LOCK),     32'(vecs[i].lock));
            $display("vec %0d %s: wbe=%0d idx=%0d data=%h busy=%h ret=%0d stall=%0d",
                     i, vecs[i].name, wif.O_WBEnable, wif.O_WBRegIdx, wif.O_WBData,
                     wif.O_Busy, wif.O_RetireCount, wif.O_StallCount);
        end

        // Async reset between edges discards the pending ADD R11
        wif.I_LOCK = 1'b1; wif.I_FetchStall = 1'b0; wif.I_DepStall = 1'b0;
        wif.I_SetBusy = 1'b1; wif.I_SetBusyIdx = 4'd12;
        wif.I_Opcode = OP_ADD; wif.I_DestRegIdx = 4'd11; wif.I_ALUOut = 16'h4444;
        wif.I_RdIdx1 = 4'd3; wif.I_RdIdx2 = 4'd11;
        #1;
        check("pre_rst_rd1", 32'(wif.O_RdData1), 32'h1234);
        check("pre_rst_rd2", 32'(wif.O_RdData2), 32'h4444);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        check("async_rst_rd1", 32'(wif.O_RdData1), 32'd0);
        $display("async reset asserted at %0t", $time);
        @(negedge clk);
        #1;
        check_all_zero("rst_held");
        idle_inputs();
        wif.I_RdIdx1 = 4'd11;
        rst = 1'b0;
        @(negedge clk);
        #1;
        check_all_zero("post_rst");
        check("post_rst_r11", 32'(wif.O_RdData1), 32'd0);
        $display("reset released, r11=%h ret=%0d", wif.O_RdData1, wif.O_RetireCount);

        // Counter wrap on the 3-bit counter instance: 7 retires reach all-ones
        wif_w.I_LOCK = 1'b1;
        repeat (7) @(negedge clk);
        #1;
        check("wrap_allones", 32'(wif_w.O_RetireCount), 32'd7);
        @(negedge clk);
        #1;
        check("wrap_zero", 32'(wif_w.O_RetireCount), 32'd0);
        $display("wrap: retire=%0d", wif_w.O_RetireCount);
        wif_w.I_LOCK = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
